// File: rtl/fade_pkg.sv
// Shared types for the RGB fade sequencer: hue phases, channel selects and
// the phase -> (channel, direction) lookup.
package fade_pkg;

    typedef enum logic [2:0] {
        PH_G_UP = 3'd0,
        PH_R_DN = 3'd1,
        PH_B_UP = 3'd2,
        PH_G_DN = 3'd3,
        PH_R_UP = 3'd4,
        PH_B_DN = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_e;

    typedef struct packed {
        chan_e ch;
        logic  up;
    } phase_act_t;

    function automatic phase_act_t phase_action(input phase_e ph);
        phase_act_t a;
        a = '{ch: CH_G, up: 1'b1};
        unique case (ph)
            PH_G_UP: a = '{ch: CH_G, up: 1'b1};
            PH_R_DN: a = '{ch: CH_R, up: 1'b0};
            PH_B_UP: a = '{ch: CH_B, up: 1'b1};
            PH_G_DN: a = '{ch: CH_G, up: 1'b0};
            PH_R_UP: a = '{ch: CH_R, up: 1'b1};
            PH_B_DN: a = '{ch: CH_B, up: 1'b0};
            default: a = '{ch: CH_G, up: 1'b1};
        endcase
        return a;
    endfunction

    function automatic phase_e next_phase(input phase_e ph);
        phase_e n;
        unique case (ph)
            PH_G_UP: n = PH_R_DN;
            PH_R_DN: n = PH_B_UP;
            PH_B_UP: n = PH_G_DN;
            PH_G_DN: n = PH_R_UP;
            PH_R_UP: n = PH_B_DN;
            default: n = PH_G_UP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with three registered duty comparators.
module pwm_gen #(
    parameter int unsigned PWM_INTERVAL = 1000,
    parameter int unsigned DW           = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] duty_r_i,
    input  logic [DW-1:0] duty_g_i,
    input  logic [DW-1:0] duty_b_i,
    output logic          pwm_r_o,
    output logic          pwm_g_o,
    output logic          pwm_b_o
);

    localparam int unsigned CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PWM_INTERVAL - 1);

    logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic          pwm_r_q, pwm_r_d;
    logic          pwm_g_q, pwm_g_d;
    logic          pwm_b_q, pwm_b_d;

    // Compare at 32 bits so counter and duty widths need not match.
    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
        pwm_r_d   = 32'(pwm_cnt_q) < 32'(duty_r_i);
        pwm_g_d   = 32'(pwm_cnt_q) < 32'(duty_g_i);
        pwm_b_d   = 32'(pwm_cnt_q) < 32'(duty_b_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt_q <= '0;
            pwm_r_q   <= 1'b0;
            pwm_g_q   <= 1'b0;
            pwm_b_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pwm_r_q   <= pwm_r_d;
            pwm_g_q   <= pwm_g_d;
            pwm_b_q   <= pwm_b_d;
        end
    end

    assign pwm_r_o = pwm_r_q;
    assign pwm_g_o = pwm_g_q;
    assign pwm_b_o = pwm_b_q;

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Colour-wheel sequencer: steps one channel per phase through a six-phase hue
// cycle and drives the three LED pins through a shared PWM generator.
module rgb_fade_sequencer
    import fade_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL    = 1000,
    parameter int unsigned STEP_INTERVAL   = 10000,
    parameter int unsigned STEPS_PER_PHASE = 200,
    parameter int unsigned STEP_VAL        = PWM_INTERVAL / STEPS_PER_PHASE,
    parameter int unsigned DUTY_MAX        = STEPS_PER_PHASE * STEP_VAL,
    parameter int unsigned DW              = $clog2(DUTY_MAX + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    output logic [DW-1:0] duty_r_o,
    output logic [DW-1:0] duty_g_o,
    output logic [DW-1:0] duty_b_o,
    output logic [2:0]    phase_o,
    output logic          phase_done_o,
    output logic          pwm_r_o,
    output logic          pwm_g_o,
    output logic          pwm_b_o
);

    localparam int unsigned PW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam int unsigned SW = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_INTERVAL - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_PHASE - 1);
    localparam logic [DW-1:0] DMAX      = DW'(DUTY_MAX);
    localparam logic [DW-1:0] DSTEP     = DW'(STEP_VAL);
    localparam logic [DW-1:0] UP_LIM    = DW'(DUTY_MAX - STEP_VAL);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    phase_e        phase_q, phase_d;
    logic          phase_done_q, phase_done_d;
    logic [DW-1:0] duty_q [3];
    logic [DW-1:0] duty_d [3];

    logic          step_tick;
    logic          last_step;
    phase_act_t    act;
    logic [DW-1:0] act_duty;
    logic [DW-1:0] stepped;

    always_comb begin
        step_tick = enable_i && (prescaler_q == PRE_LAST);
        last_step = step_tick && (step_cnt_q == STEP_LAST);
        act       = phase_action(phase_q);
        act_duty  = duty_q[act.ch];

        if (act.up) begin
            stepped = (act_duty >= UP_LIM) ? DMAX : act_duty + DSTEP;
        end else begin
            stepped = (act_duty <= DSTEP) ? '0 : act_duty - DSTEP;
        end
        // Land exactly on the rail at the end of a phase regardless of rounding.
        if (last_step) begin
            stepped = act.up ? DMAX : '0;
        end

        prescaler_d = prescaler_q;
        if (enable_i) begin
            prescaler_d = step_tick ? '0 : prescaler_q + 1'b1;
        end

        step_cnt_d = step_cnt_q;
        duty_d     = duty_q;
        if (step_tick) begin
            step_cnt_d      = last_step ? '0 : step_cnt_q + 1'b1;
            duty_d[act.ch]  = stepped;
        end

        phase_d      = last_step ? next_phase(phase_q) : phase_q;
        phase_done_d = last_step;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescaler_q  <= '0;
            step_cnt_q   <= '0;
            phase_q      <= PH_G_UP;
            phase_done_q <= 1'b0;
            duty_q[CH_R] <= DMAX;
            duty_q[CH_G] <= '0;
            duty_q[CH_B] <= '0;
        end else begin
            prescaler_q  <= prescaler_d;
            step_cnt_q   <= step_cnt_d;
            phase_q      <= phase_d;
            phase_done_q <= phase_done_d;
            duty_q       <= duty_d;
        end
    end

    assign duty_r_o     = duty_q[CH_R];
    assign duty_g_o     = duty_q[CH_G];
    assign duty_b_o     = duty_q[CH_B];
    assign phase_o      = phase_q;
    assign phase_done_o = phase_done_q;

    pwm_gen #(
        .PWM_INTERVAL (PWM_INTERVAL),
        .DW           (DW)
    ) u_pwm_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .duty_r_i (duty_q[CH_R]),
        .duty_g_i (duty_q[CH_G]),
        .duty_b_i (duty_q[CH_B]),
        .pwm_r_o  (pwm_r_o),
        .pwm_g_o  (pwm_g_o),
        .pwm_b_o  (pwm_b_o)
    );

endmodule
